// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Interlock and redirect controller for a five-stage pipeline (IF, ID, EX,
//   MEM, WB). A two-slot scoreboard tracks the destinations of the
//   instructions now in EX and MEM. IF/ID is stalled on read-after-write
//   hazards, and younger work is flushed when a branch resolves taken in MEM.
//   WB producers never stall because the register file bypasses writes to ID
//   in the same cycle.
//
//   Optional feature macro: HAZARD_FWD_EN
//     defined   : load-use-only interlock plus registered EX forwarding selects
//     undefined : full RAW interlock against both slots, fwd_a/fwd_b fixed 00
//
// Ports
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   id_valid             ID holds a real instruction
//   id_rs, id_rt         ID source addresses
//   id_uses_rs/rt        the corresponding source is read
//   id_rd, id_we         ID destination and its write enable
//   id_is_load           ID instruction is a load
//   mem_branch_taken     branch in MEM resolved taken this cycle
//   pc_we, ifid_we       PC and IF/ID enables
//   ifid_flush           clear IF/ID to a bubble
//   idex_bubble          load a bubble into ID/EX
//   exmem_flush          clear EX/MEM to a bubble
//   fwd_a, fwd_b         EX operand source (00 RF, 01 EX/MEM, 10 MEM/WB)
//   ctrl_state           00 RUN, 01 STALL, 10 REDIRECT
//   stall_count          saturating count of hazard stall cycles

module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              mem_branch_taken,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        ctrl_state,
  output logic [CNT_W-1:0]  stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_STALL    = 2'b01,
    ST_REDIRECT = 2'b10
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic                sb_ex_valid_r;
  logic [REG_AW-1:0]   sb_ex_rd_r;
  logic                sb_ex_load_r;
  logic                sb_mem_valid_r;
  logic [REG_AW-1:0]   sb_mem_rd_r;
  logic [CNT_W-1:0]    stall_count_r;
  logic                rs_ex_s, rt_ex_s, rs_mem_s, rt_mem_s;
  logic                hazard_s;
  logic                stall_s;
  logic                advance_s;

  // A source depends on a slot only if it is really read, is not r0, and the
  // slot holds a live writer of that register.
  function automatic logic src_match(input logic uses, input logic [REG_AW-1:0] addr,
                                     input logic slot_valid, input logic [REG_AW-1:0] slot_rd);
    return uses && (addr != {REG_AW{1'b0}}) && slot_valid && (addr == slot_rd);
  endfunction

  assign rs_ex_s  = id_valid & src_match(id_uses_rs, id_rs, sb_ex_valid_r,  sb_ex_rd_r);
  assign rt_ex_s  = id_valid & src_match(id_uses_rt, id_rt, sb_ex_valid_r,  sb_ex_rd_r);
  assign rs_mem_s = id_valid & src_match(id_uses_rs, id_rs, sb_mem_valid_r, sb_mem_rd_r);
  assign rt_mem_s = id_valid & src_match(id_uses_rt, id_rt, sb_mem_valid_r, sb_mem_rd_r);

  // Hazard detection; ID holds a flushed bubble while in REDIRECT.
  always_comb begin
    hazard_s = 1'b0;
    if (state_r == ST_REDIRECT) begin
      hazard_s = 1'b0;
    end else begin
`ifdef HAZARD_FWD_EN
      hazard_s = (rs_ex_s | rt_ex_s) & sb_ex_load_r;
`else
      hazard_s = rs_ex_s | rt_ex_s | rs_mem_s | rt_mem_s;
`endif
    end
  end

  assign stall_s   = hazard_s & ~mem_branch_taken;
  assign advance_s = id_valid & ~hazard_s & ~mem_branch_taken;

  // Next state and pipeline control outputs: redirect beats stall beats run.
  always_comb begin
    state_next_s = ST_RUN;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_flush  = 1'b0;
    if (mem_branch_taken) begin
      state_next_s = ST_REDIRECT;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
    end else if (hazard_s) begin
      state_next_s = ST_STALL;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      idex_bubble  = 1'b1;
    end else begin
      state_next_s = ST_RUN;
    end
  end

  // Controller state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Scoreboard: EX slot takes the advancing ID instruction, MEM slot follows EX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sb_ex_valid_r  <= 1'b0;
      sb_ex_rd_r     <= {REG_AW{1'b0}};
      sb_ex_load_r   <= 1'b0;
      sb_mem_valid_r <= 1'b0;
      sb_mem_rd_r    <= {REG_AW{1'b0}};
    end else if (mem_branch_taken) begin
      sb_ex_valid_r  <= 1'b0;
      sb_ex_rd_r     <= {REG_AW{1'b0}};
      sb_ex_load_r   <= 1'b0;
      sb_mem_valid_r <= 1'b0;
      sb_mem_rd_r    <= {REG_AW{1'b0}};
    end else begin
      sb_mem_valid_r <= sb_ex_valid_r;
      sb_mem_rd_r    <= sb_ex_rd_r;
      sb_ex_valid_r  <= advance_s & id_we & (id_rd != {REG_AW{1'b0}});
      sb_ex_rd_r     <= id_rd;
      sb_ex_load_r   <= advance_s & id_is_load;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall_count = stall_count_r;
  assign ctrl_state  = state_r;

`ifdef HAZARD_FWD_EN
  logic [1:0] fwd_a_r;
  logic [1:0] fwd_b_r;

  // The EX-slot producer sits in EX/MEM when the consumer reaches EX, so it
  // wins over the older MEM-slot producer that will be in MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
    logic [1:0] sel;
    if (hit_ex) begin
      sel = 2'b01;
    end else if (hit_mem) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects follow the instruction into EX; a bubble never forwards.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end else if (advance_s) begin
      fwd_a_r <= fwd_sel(rs_ex_s, rs_mem_s);
      fwd_b_r <= fwd_sel(rt_ex_s, rt_mem_s);
    end else begin
      fwd_a_r <= 2'b00;
      fwd_b_r <= 2'b00;
    end
  end

  assign fwd_a = fwd_a_r;
  assign fwd_b = fwd_b_r;
`else
  logic unused_load_s;

  assign unused_load_s = sb_ex_load_r;
  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. A behavioural model tracks the
// destination register of the instruction in EX and in MEM (0 = none) and
// derives the expected controls from the hazard/redirect rules.
// The counter is built narrow so that saturation is reached in few cycles.

module tb_pipeline_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic          id_valid;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic          id_uses_rs, id_uses_rt, id_we, id_is_load;
  logic          mem_branch_taken;
  logic          pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush;
  logic [1:0]    fwd_a, fwd_b, ctrl_state;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
    .mem_branch_taken(mem_branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_flush(exmem_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .ctrl_state(ctrl_state), .stall_count(stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: in-flight destinations (0 = no write) for EX and MEM.
  int fl_rd[2];
  bit fl_ld_ex;
  int m_state;   // 0 RUN, 1 STALL, 2 REDIRECT
  int m_cnt;
  int m_fa, m_fb;
  int last_ctl;

  task automatic model_reset();
    fl_rd[0] = 0; fl_rd[1] = 0; fl_ld_ex = 0;
    m_state = 0; m_cnt = 0; m_fa = 0; m_fb = 0;
  endtask

  function automatic bit hit(input int addr, input bit uses, input int slot);
    return uses && addr != 0 && addr == fl_rd[slot];
  endfunction

  function automatic int pick(input bit ex, input bit mem);
    if (ex) return 1;
    if (mem) return 2;
    return 0;
  endfunction

  // One clock: drive ID/MEM inputs, compare at the falling edge, step model.
  task automatic cycle(input bit v, input int rs, input int rt, input bit urs_i, input bit urt_i,
                       input int rd, input bit we, input bit ld, input bit br, output bit adv);
    bit urs, urt, rsx, rtx, rsm, rtm, hz;
    int exp_ctl, n_fa, n_fb, n_state;
    urs = urs_i & v;
    urt = urt_i & v;
    id_valid = v; id_rs = rs[AW-1:0]; id_rt = rt[AW-1:0];
    id_uses_rs = urs; id_uses_rt = urt; id_rd = rd[AW-1:0];
    id_we = we; id_is_load = ld; mem_branch_taken = br;
    @(negedge clock);
    rsx = hit(rs, urs, 0); rtx = hit(rt, urt, 0);
    rsm = hit(rs, urs, 1); rtm = hit(rt, urt, 1);
    if (FWD) hz = (rsx || rtx) && fl_ld_ex;
    else     hz = rsx || rtx || rsm || rtm;
    if (m_state == 2) hz = 0;
    if (br)      exp_ctl = 5'b11111;
    else if (hz) exp_ctl = 5'b00010;
    else         exp_ctl = 5'b11000;
    last_ctl = {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush};
    check("ctl", last_ctl, exp_ctl);
    check("fwd_a", fwd_a, m_fa);
    check("fwd_b", fwd_b, m_fb);
    check("state", ctrl_state, m_state);
    check("count", stall_count, m_cnt);
    adv = v && !hz && !br;
    n_fa = (FWD && adv) ? pick(rsx, rsm) : 0;
    n_fb = (FWD && adv) ? pick(rtx, rtm) : 0;
    n_state = br ? 2 : (hz ? 1 : 0);
    @(posedge clock);
    if (hz && !br && m_cnt < MAXC) m_cnt++;
    m_state = n_state; m_fa = n_fa; m_fb = n_fb;
    if (br) begin
      fl_rd[0] = 0; fl_rd[1] = 0; fl_ld_ex = 0;
    end else begin
      fl_rd[1] = fl_rd[0];
      fl_rd[0] = (adv && we) ? rd : 0;
      fl_ld_ex = adv && ld;
    end
    #1;
  endtask

  // Present one instruction until it advances; returns the stall cycles spent.
  task automatic issue(input int rs, input int rt, input bit urs, input bit urt,
                       input int rd, input bit we, input bit ld, output int stalls);
    bit adv;
    stalls = 0;
    adv = 0;
    for (int k = 0; k < 8 && !adv; k++) begin
      cycle(1, rs, rt, urs, urt, rd, we, ld, 0, adv);
      if (!adv) stalls++;
    end
    check("issue_advanced", adv, 1);
  endtask

  task automatic idle(input int n);
    bit adv;
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, adv);
  endtask

  initial begin
    int st, c0;
    bit adv;
    reset = 1'b1;
    id_valid = 0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_uses_rs = 0; id_uses_rt = 0; id_we = 0; id_is_load = 0; mem_branch_taken = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset values
    check("rst_state", ctrl_state, 0);
    check("rst_count", stall_count, 0);
    check("rst_pc_we", pc_we, 1);
    check("rst_ifid_we", ifid_we, 1);
    check("rst_fwd_a", fwd_a, 0);
    idle(1);

    // ALU back-to-back: write r3, next reads rs=r3
    issue(0, 0, 0, 0, 3, 1, 0, st);
    issue(3, 0, 1, 0, 6, 1, 0, st);
    check("alu_bubbles", st, FWD ? 0 : 2);
    check("alu_fwd_a", fwd_a, FWD ? 1 : 0);
    check("alu_count", stall_count, FWD ? 0 : 2);
    idle(2);

    // Load-use: load r5, next reads rt=r5
    issue(0, 0, 0, 0, 5, 1, 1, st);
    issue(0, 5, 0, 1, 0, 0, 0, st);
    check("lu_bubbles", st, FWD ? 1 : 2);
    check("lu_fwd_b", fwd_b, FWD ? 2 : 0);
    idle(2);

    // r0 writes never create a dependency
    issue(0, 0, 0, 0, 0, 1, 0, st);
    issue(0, 0, 1, 1, 1, 1, 0, st);
    check("r0_bubbles", st, 0);
    check("r0_fwd_a", fwd_a, 0);
    idle(2);

    // Branch taken in the same cycle as a load-use hazard
    issue(0, 0, 0, 0, 7, 1, 1, st);
    c0 = m_cnt;
    cycle(1, 0, 7, 0, 1, 0, 0, 0, 1, adv);
    check("br_ctl", last_ctl, 5'b11111);
    check("br_state", ctrl_state, 2);
    check("br_count", stall_count, c0);
    idle(1);
    check("br_state_after", ctrl_state, 0);

    // Reset asserted mid-stall
    issue(0, 0, 0, 0, 4, 1, 1, st);
    cycle(1, 4, 0, 1, 0, 0, 0, 0, 0, adv);
    @(negedge clock);
    check("rst_mid_pre", ctrl_state, 1);
    reset = 1'b1;
    #1;
    check("rst_mid_state", ctrl_state, 0);
    check("rst_mid_count", stall_count, 0);
    check("rst_mid_pc_we", pc_we, 1);
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;

    // Randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, adv);
    end

    // Saturation: reach all-ones minus one, then stall further
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    for (int k = 0; k < 200 && m_cnt < MAXC - 1; k++) begin
      issue(0, 0, 0, 0, 2, 1, 1, st);
      issue(2, 0, 1, 0, 0, 0, 0, st);
    end
    check("sat_pre", stall_count, MAXC - 1);
    for (int k = 0; k < 3; k++) begin
      issue(0, 0, 0, 0, 2, 1, 1, st);
      issue(2, 0, 1, 0, 0, 0, 0, st);
    end
    check("sat_hold", stall_count, MAXC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Interlock and redirect controller for the five-stage pipeline (IF, ID, EX, MEM, WB). It tracks in-flight destination registers in a two-slot scoreboard and stalls IF/ID on read-after-write hazards. It flushes younger instructions when a branch resolves taken in MEM. When forwarding is compiled in, it also drives registered EX-stage forwarding selects. Register-file writes in WB are visible to ID in the same cycle (double bump), so WB producers never cause a stall.

## Interface
Parameters:
- `REG_AW`, default 5: register address width.
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clock`, in, 1: single clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `id_valid`, in, 1: ID holds a real instruction.
- `id_rs`, `id_rt`, in, REG_AW each: ID source register addresses.
- `id_uses_rs`, `id_uses_rt`, in, 1 each: the corresponding source is actually read.
- `id_rd`, in, REG_AW: ID destination register.
- `id_we`, in, 1: the ID instruction writes `id_rd`.
- `id_is_load`, in, 1: the ID instruction is a load.
- `mem_branch_taken`, in, 1: branch in MEM resolved taken this cycle.
- `pc_we`, out, 1: PC update enable.
- `ifid_we`, out, 1: IF/ID register enable.
- `ifid_flush`, out, 1: clear IF/ID to a bubble.
- `idex_bubble`, out, 1: load a bubble into ID/EX.
- `exmem_flush`, out, 1: clear EX/MEM to a bubble.
- `fwd_a`, `fwd_b`, out, 2 each: EX operand source. 00 = register file, 01 = EX/MEM ALU output, 10 = MEM/WB result.
- `ctrl_state`, out, 2: 00 RUN, 01 STALL, 10 REDIRECT.
- `stall_count`, out, CNT_W: saturating count of hazard stall cycles.

## Operation
- **Scoreboard.** Two slots, `sb_ex` and `sb_mem`, each holding {valid, rd, is_load}.
  - Every clock edge: `sb_mem` <= `sb_ex`.
  - `sb_ex` <= the ID instruction's info when it advances (`id_valid`, no stall, no redirect); otherwise `sb_ex` <= invalid.
  - A slot counts only if valid, we=1 and rd≠0.
- **Source match.** A source matches a slot when its uses_* flag is set, its address is nonzero, and the address equals the slot's rd.
- **Hazard, without forwarding.** Any ID source matches `sb_ex` or `sb_mem`.
- **Hazard, with forwarding.** Any ID source matches `sb_ex` and `sb_ex.is_load`=1 (load-use).
- **Priority.** Redirect beats stall beats run.
- **Redirect** (`mem_branch_taken`=1):
  - Outputs: `pc_we`=1, `ifid_we`=1, `ifid_flush`=1, `idex_bubble`=1, `exmem_flush`=1.
  - Both scoreboard slots become invalid at the edge.
  - Next state is REDIRECT.
- **Stall** (hazard, no redirect):
  - Outputs: `pc_we`=0, `ifid_we`=0, `idex_bubble`=1.
  - Next state is STALL; `stall_count` increments, saturating at all-ones.
- **Run:**
  - Outputs: `pc_we`=1, `ifid_we`=1; all flush and bubble outputs 0.
  - Next state is RUN.
- **REDIRECT state.** Lasts exactly one cycle. Hazard checks are suppressed in this state because ID holds a flushed bubble. A new `mem_branch_taken` still redirects.
- **Reset.** State RUN, scoreboard invalid, `fwd_a`/`fwd_b`=00, `stall_count`=0. Combinational outputs then read `pc_we`=1, `ifid_we`=1, all others 0.

## Timing
- Stall, flush and enable outputs are combinational from the ID inputs, `mem_branch_taken` and registered state. They are valid in the same cycle.
- `fwd_a`/`fwd_b` are registered. They are computed in ID and presented during that instruction's EX cycle, one cycle of latency.
- A load-use hazard costs 1 bubble with forwarding. A dependency on the immediately preceding ALU instruction costs 2 bubbles without forwarding.
- When `mem_branch_taken` coincides with a hazard, the redirect wins and `stall_count` does not increment.
- Reset asserted mid-stall or mid-redirect returns everything to the reset values immediately (asynchronous).

## Configuration
- Macro `HAZARD_FWD_EN`.
- **Defined:**
  - Load-use-only hazard rule.
  - Registered forwarding: a match on `sb_ex` gives 01, otherwise a match on `sb_mem` gives 10. The `sb_ex` match has priority when both slots hold the same rd.
  - The bubble slot never forwards.
- **Undefined:**
  - Full RAW interlock against both slots.
  - `fwd_a` and `fwd_b` are constant 00.

## Test plan
- **Reset.** Assert `reset` mid-cycle during a STALL → `ctrl_state`=00, `stall_count`=0, `pc_we`=1 before the next edge.
- **ALU back-to-back.** Write r3, then the next instruction reads rs=r3.
  - Without the macro → 2 cycles of `idex_bubble`=1 and `stall_count`=2.
  - With it → 0 stalls and `fwd_a`=01 in the consumer's EX cycle.
- **Load-use.** Load r5, then the next instruction reads rt=r5, with the macro → 1 bubble, then `fwd_b`=10 in the consumer's EX cycle.
- **r0 write.** Instruction writes r0, then the next instruction reads r0 → no stall; `fwd_a`=00.
- **Branch vs. stall.** `mem_branch_taken`=1 in the same cycle as a load-use hazard → `ifid_flush`=`idex_bubble`=`exmem_flush`=1, `pc_we`=1, count unchanged, `ctrl_state`=10 for 1 cycle, then 00.
- **Saturation.** Preload `stall_count` to 16'hFFFE via 2 fewer stalls than wrap, then add 3 more stall cycles → `stall_count` holds 16'hFFFF.
